// File: rtl/fa4_pkg.sv
// Shared definitions for the dual-path 4-bit adder block.
package fa4_pkg;

    // Operand width the block is built and verified for.
    localparam int unsigned FA4_WIDTH = 4;

    // Sum/carry result of one add: carry-out above the sum bits.
    typedef struct packed {
        logic                 co;
        logic [FA4_WIDTH-1:0] s;
    } fa4_result_t;

    // Pack a carry-out and sum into the shared result type.
    function automatic fa4_result_t fa4_pack(input logic co, input logic [FA4_WIDTH-1:0] s);
        fa4_result_t r;
        r.co = co;
        r.s  = s;
        return r;
    endfunction

endpackage : fa4_pkg

// File: rtl/full_adder.sv
// One-bit full adder: the cell the ripple path chains together.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum is the three-way parity; carry is the majority of the three inputs.
    always_comb begin
        sum  = x ^ y ^ cin;
        cout = (x & y) | (x & cin) | (y & cin);
    end

endmodule : full_adder

// File: rtl/fa4_dual_adder.sv
// Adds a + b + ci two ways (ripple of full adders, single vector add),
// registers both results with one cycle of latency and flags any disagreement.
module fa4_dual_adder
    import fa4_pkg::*;
#(
    parameter int unsigned WIDTH = FA4_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s1,
    output logic             co1,
    output logic [WIDTH-1:0] s2,
    output logic             co2,
    output logic             out_valid,
    output logic             mismatch
);

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] rip_sum;
    logic [WIDTH:0]   rip_res;
    logic [WIDTH:0]   vec_res;
    logic             diff;

    // Ripple path: bit 0 takes the external carry-in, every other bit
    // takes the carry-out of the bit below it.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        if (gi == 0) begin : g_lsb
            full_adder u_fa (
                .x    (a[gi]),
                .y    (b[gi]),
                .cin  (ci),
                .sum  (rip_sum[gi]),
                .cout (carry[gi])
            );
        end else begin : g_upper
            full_adder u_fa (
                .x    (a[gi]),
                .y    (b[gi]),
                .cin  (carry[gi-1]),
                .sum  (rip_sum[gi]),
                .cout (carry[gi])
            );
        end
    end

    // Collect both paths as {carry, sum} and compare them in the same cycle.
    always_comb begin
        rip_res = {carry[WIDTH-1], rip_sum};
        vec_res = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        diff    = (rip_res != vec_res);
    end

    // Output registers: reset wins, valid input loads, otherwise results hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            co1       <= 1'b0;
            s2        <= '0;
            co2       <= 1'b0;
            out_valid <= 1'b0;
            mismatch  <= 1'b0;
        end else if (in_valid) begin
            {co1, s1} <= rip_res;
            {co2, s2} <= vec_res;
            out_valid <= 1'b1;
            mismatch  <= diff;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule : fa4_dual_adder

// File: tb/tb_fa4_dual_adder.sv
// Self-checking bench for fa4_dual_adder: directed cases, exhaustive sweep
// and random vectors against an arithmetic reference model.
module tb_fa4_dual_adder;
    import fa4_pkg::*;

    localparam int unsigned W = FA4_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s1;
    logic         co1;
    logic [W-1:0] s2;
    logic         co2;
    logic         out_valid;
    logic         mismatch;

    int nchecks = 0;
    int nerrors = 0;

    // Reference state: what the registered outputs should show.
    int unsigned exp_sum = 0;
    int unsigned exp_co  = 0;
    int unsigned exp_ov  = 0;

    fa4_dual_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .s1        (s1),
        .co1       (co1),
        .s2        (s2),
        .co2       (co2),
        .out_valid (out_valid),
        .mismatch  (mismatch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".s1"},        {28'd0, s1},        exp_sum);
        chk({tag, ".co1"},       {31'd0, co1},       exp_co);
        chk({tag, ".s2"},        {28'd0, s2},        exp_sum);
        chk({tag, ".co2"},       {31'd0, co2},       exp_co);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, exp_ov);
        chk({tag, ".mismatch"},  {31'd0, mismatch},  0);
    endtask

    // Apply one cycle of stimulus, advance the model, then sample after the edge.
    task automatic step(input logic r, input logic v, input int unsigned av,
                        input int unsigned bv, input int unsigned cv, input string tag);
        int unsigned total;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = av[W-1:0];
        b        = bv[W-1:0];
        ci       = cv[0];
        @(posedge clk);
        #1;
        if (r) begin
            exp_sum = 0;
            exp_co  = 0;
            exp_ov  = 0;
        end else if (v) begin
            total   = (av % 16) + (bv % 16) + (cv % 2);
            exp_sum = total % (1 << W);
            exp_co  = total / (1 << W);
            exp_ov  = 1;
        end else begin
            exp_ov  = 0;
        end
        check_all(tag);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        ci       = 1'b0;

        // Reset state, with a valid input presented during reset.
        step(1'b1, 1'b0, 0, 0, 0, "reset0");
        step(1'b1, 1'b1, 7, 6, 1, "reset_valid");

        // First valid result appears one cycle after the first valid input.
        step(1'b0, 1'b0, 2, 2, 0, "post_reset_idle");
        step(1'b0, 1'b1, 5, 3, 0, "basic_5p3");

        // Carry-out and wrap-around.
        step(1'b0, 1'b1, 15, 1, 0, "wrap_15p1");
        step(1'b0, 1'b1, 15, 15, 1, "wrap_15p15p1");
        chk("wrap_max_sum", {28'd0, s1}, 15);

        // Carry-in only, then hold for three idle cycles.
        step(1'b0, 1'b1, 0, 0, 1, "cin_only");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 12, 9, 1, $sformatf("hold%0d", i));
        end

        // Exhaustive sweep over {ci, a, b}.
        for (int i = 0; i < 512; i++) begin
            step(1'b0, 1'b1, (i >> 4) & 15, i & 15, (i >> 8) & 1,
                 $sformatf("exh_c%0d_a%0d_b%0d", (i >> 8) & 1, (i >> 4) & 15, i & 15));
        end

        // Reset mid-stream discards the concurrent input.
        step(1'b1, 1'b1, 9, 9, 0, "reset_mid");
        step(1'b0, 1'b1, 9, 9, 0, "after_reset_9p9");
        chk("after_reset_9p9_carry", {31'd0, co2}, 1);

        // Random vectors with occasional idle cycles.
        for (int i = 0; i < 40; i++) begin
            int unsigned ra, rb, rc, rv;
            ra = $urandom_range(15, 0);
            rb = $urandom_range(15, 0);
            rc = $urandom_range(1, 0);
            rv = ($urandom_range(3, 0) != 0) ? 1 : 0;
            step(1'b0, rv[0], ra, rb, rc, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule : tb_fa4_dual_adder
